// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and default widths for the AXI-Stream packet generator.
// Widths match the FIFO wrapper the generator usually feeds.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_WIDTH_TDATA = 16;
    localparam int DEF_WIDTH_TUSER = 4;
    localparam int DEF_MAX_LEN     = 1024;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream test-traffic source: framed packets, incrementing tdata, packet-indexed tuser.
// Latency: start at cycle N gives the first valid beat at N+1; one beat per cycle while tready is high.
// Backpressure: beats are held stable until accepted; tvalid is a pure state decode, never a function of tready.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int WIDTH_TDATA = DEF_WIDTH_TDATA,
    parameter int WIDTH_TUSER = DEF_WIDTH_TUSER,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int WIDTH_LEN   = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [WIDTH_LEN-1:0]   cfg_len,
    input  logic [15:0]            cfg_num_pkts,
    input  logic [7:0]             cfg_gap,
    input  logic [WIDTH_TDATA-1:0] cfg_seed,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkt_cnt,
    output logic                   axis_m_tvalid,
    output logic [WIDTH_TDATA-1:0] axis_m_tdata,
    output logic [WIDTH_TUSER-1:0] axis_m_tuser,
    output logic                   axis_m_tlast,
    input  logic                   axis_m_tready
);

    state_t                 state_q, nxt_state;
    logic [WIDTH_LEN-1:0]   len_q;
    logic [WIDTH_LEN-1:0]   beat_q;
    logic [15:0]            num_q;
    logic [7:0]             gap_q;
    logic [7:0]             gap_cnt_q;
    logic [WIDTH_TDATA-1:0] data_q;
    logic [15:0]            pkt_cnt_q;
    logic                   stop_q;
    logic                   last_q;
    logic                   done_q;

    logic [WIDTH_LEN-1:0]   len_in;
    logic                   start_ok;
    logic                   beat_hs;
    logic                   pkt_end;
    logic                   num_hit;
    logic                   end_run;
    logic [15:0]            pkt_cnt_inc;
    logic                   nxt_is_last;

    assign len_in      = (cfg_len > WIDTH_LEN'(MAX_LEN)) ? WIDTH_LEN'(MAX_LEN) : cfg_len;
    assign start_ok    = cfg_start && (cfg_len != '0);
    assign beat_hs     = (state_q == SEND) && axis_m_tready;
    assign pkt_end     = beat_hs && last_q;
    // 17-bit compare so a saturated counter can never alias onto num_q
    assign num_hit     = (num_q != 16'd0) && (({1'b0, pkt_cnt_q} + 17'd1) == {1'b0, num_q});
    // a stop arriving on the tlast handshake itself still ends the run
    assign end_run     = stop_q || cfg_stop || num_hit;
    assign pkt_cnt_inc = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
    assign nxt_is_last = ((WIDTH_LEN+1)'(beat_q) + (WIDTH_LEN+1)'(2)) == (WIDTH_LEN+1)'(len_q);

    always_comb begin
        nxt_state = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) nxt_state = SEND;
            end
            SEND: begin
                if (pkt_end) begin
                    if (end_run)              nxt_state = IDLE;
                    else if (gap_q != 8'd0)   nxt_state = GAP;
                    else                      nxt_state = SEND;
                end
            end
            GAP: begin
                if (stop_q || cfg_stop)       nxt_state = IDLE;
                else if (gap_cnt_q == 8'd1)   nxt_state = SEND;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            pkt_cnt_q <= '0;
            stop_q    <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= nxt_state;
            done_q  <= (state_q != IDLE) && (nxt_state == IDLE);
            case (state_q)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (start_ok) begin
                        len_q     <= len_in;
                        num_q     <= cfg_num_pkts;
                        gap_q     <= cfg_gap;
                        data_q    <= cfg_seed;
                        beat_q    <= '0;
                        pkt_cnt_q <= 16'd0;
                        last_q    <= (len_in == WIDTH_LEN'(1));
                    end
                end
                SEND: begin
                    if (cfg_stop) stop_q <= 1'b1;
                    if (beat_hs) begin
                        data_q <= data_q + WIDTH_TDATA'(1);
                        if (last_q) begin
                            beat_q    <= '0;
                            last_q    <= (len_q == WIDTH_LEN'(1));
                            pkt_cnt_q <= pkt_cnt_inc;
                            gap_cnt_q <= gap_q;
                        end else begin
                            beat_q <= beat_q + WIDTH_LEN'(1);
                            last_q <= nxt_is_last;
                        end
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy          = (state_q != IDLE);
        done          = done_q;
        pkt_cnt       = pkt_cnt_q;
        axis_m_tvalid = (state_q == SEND);
        axis_m_tdata  = data_q;
        axis_m_tuser  = pkt_cnt_q[WIDTH_TUSER-1:0];
        axis_m_tlast  = last_q;
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: directed runs feed a scoreboard of expected beats,
// a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_axis_pkt_gen;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_stop;
    logic [10:0] cfg_len;
    logic [15:0] cfg_num_pkts;
    logic [7:0]  cfg_gap;
    logic [15:0] cfg_seed;
    logic        busy, done;
    logic [15:0] pkt_cnt;
    logic        tvalid, tlast, tready;
    logic [15:0] tdata;
    logic [3:0]  tuser;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    hs_cnt = 0;
    int    last_hs_cyc = 0;
    bit    sb_en   = 1'b1;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic [3:0]  prev_u;
    logic        prev_l;

    axis_pkt_gen dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_len       (cfg_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_gap       (cfg_gap),
        .cfg_seed      (cfg_seed),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt),
        .axis_m_tvalid (tvalid),
        .axis_m_tdata  (tdata),
        .axis_m_tuser  (tuser),
        .axis_m_tlast  (tlast),
        .axis_m_tready (tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // expected stream: data continues across packets, tuser is packet index mod 16
    task automatic push_pkts(input int n, input int len, input logic [15:0] seed, input int pkt0);
        beat_t b;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < len; i++) begin
                b.d = seed + 16'(p * len + i);
                b.u = 4'(pkt0 + p);
                b.l = (i == len - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic start(input logic [10:0] len, input logic [15:0] num,
                         input logic [7:0] gap, input logic [15:0] seed);
        @(posedge clk); #1;
        cfg_len = len; cfg_num_pkts = num; cfg_gap = gap; cfg_seed = seed;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_pkts, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("done_latency", cyc, last_hs_cyc + 1);
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", limit);
        end else begin
            @(negedge clk);
            chk("done_pulse_width", {31'd0, done}, 32'd0);
        end
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tready = rand_rdy ? 1'($urandom % 2) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", {31'd0, tvalid}, 32'd1);
                chk("hold_dat", {16'd0, tdata}, {16'd0, prev_d});
                chk("hold_usr", {28'd0, tuser}, {28'd0, prev_u});
                chk("hold_last", {31'd0, tlast}, {31'd0, prev_l});
            end
            prev_stall <= tvalid && !tready;
            prev_d <= tdata; prev_u <= tuser; prev_l <= tlast;
            if (sb_en && tvalid && tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", {16'd0, tdata}, {16'd0, e.d});
                    chk("tuser", {28'd0, tuser}, {28'd0, e.u});
                    chk("tlast", {31'd0, tlast}, {31'd0, e.l});
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int base;
        rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_len = '0; cfg_num_pkts = '0; cfg_gap = '0; cfg_seed = '0;
        #1;
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_pktcnt", {16'd0, pkt_cnt}, 32'd0);
        chk("rst_tdata",  {16'd0, tdata},  32'd0);
        chk("rst_tlast",  {31'd0, tlast},  32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // back-to-back packets; a second start while busy must be ignored
        push_pkts(2, 4, 16'h0010, 0);
        start(11'd4, 16'd2, 8'd0, 16'h0010);
        chk("first_vld", {31'd0, tvalid}, 32'd1);
        chk("busy_on", {31'd0, busy}, 32'd1);
        cfg_seed = 16'h0099; cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        wait_done(2, 40);

        // gap of two idle cycles between packets
        push_pkts(2, 3, 16'h0100, 0);
        start(11'd3, 16'd2, 8'd2, 16'h0100);
        pat = 8'b1110_0111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("gap_vld%0d", i), {31'd0, tvalid}, {31'd0, pat[7-i]});
        end
        wait_done(2, 20);

        // random backpressure with tdata wrapping through 0xFFFF
        rand_rdy = 1'b1;
        push_pkts(3, 5, 16'hFFFE, 0);
        start(11'd5, 16'd3, 8'd1, 16'hFFFE);
        wait_done(3, 400);
        rand_rdy = 1'b0;

        // continuous mode, stop mid-packet 2 must not truncate it
        push_pkts(2, 8, 16'h2000, 0);
        base = hs_cnt;
        start(11'd8, 16'd0, 8'd1, 16'h2000);
        for (int i = 0; i < 200 && hs_cnt < base + 11; i++) @(negedge clk);
        @(posedge clk); #1 cfg_stop = 1'b1;
        @(posedge clk); #1 cfg_stop = 1'b0;
        wait_done(2, 60);
        repeat (3) @(negedge clk);
        chk("after_stop_vld", {31'd0, tvalid}, 32'd0);

        // zero length start is ignored
        start(11'd0, 16'd1, 8'd0, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("len0_vld", {31'd0, tvalid}, 32'd0);
            chk("len0_busy", {31'd0, busy}, 32'd0);
        end

        // oversize length clamps to 1024 beats
        push_pkts(1, 1024, 16'h0000, 0);
        start(11'd2000, 16'd1, 8'd0, 16'h0000);
        wait_done(1, 1200);

        // reset mid-packet clears outputs at once, restart uses new seed
        sb_en = 1'b0;
        start(11'd8, 16'd0, 8'd0, 16'h0055);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_vld", {31'd0, tvalid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pktcnt", {16'd0, pkt_cnt}, 32'd0);
        chk("arst_tlast", {31'd0, tlast}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        push_pkts(1, 2, 16'hABCD, 0);
        start(11'd2, 16'd1, 8'd0, 16'hABCD);
        wait_done(1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream packet transmitter that produces framed test traffic (incrementing data, packet-indexed tuser, tlast) for the input side of axis_param_fifo and other stream sinks. It is controlled by a start/stop pulse interface and honours downstream backpressure, so it acts as the traffic source in loopback and FIFO benches.

## Interface
Parameters:
- WIDTH_TDATA, 16, tdata width
- WIDTH_TUSER, 4, tuser width; carries packet index modulo 2^WIDTH_TUSER
- MAX_LEN, 1024, maximum beats per packet
- WIDTH_LEN, $clog2(MAX_LEN+1), width of length fields

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk by upstream reset logic)
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_stop  in  1  one-cycle stop request; finish current packet, then IDLE
- cfg_len  in  WIDTH_LEN  beats per packet, latched on start
- cfg_num_pkts  in  16  packets to send; 0 = continuous until stop
- cfg_gap  in  8  idle cycles between packets, latched on start
- cfg_seed  in  WIDTH_TDATA  first tdata value, latched on start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when returning to IDLE
- pkt_cnt  out  16  packets completed since last start
- axis_m_tvalid  out  1
- axis_m_tdata  out  WIDTH_TDATA
- axis_m_tuser  out  WIDTH_TUSER
- axis_m_tlast  out  1
- axis_m_tready  in  1

## Operation
- States: IDLE, SEND, GAP.
- IDLE: cfg_start with cfg_len != 0 latches cfg_*; data counter = cfg_seed, beat = 0, pkt_cnt = 0; go to SEND. cfg_start with cfg_len == 0 is ignored. cfg_len > MAX_LEN is clamped to MAX_LEN.
- SEND: tvalid = 1; tdata = data counter; tuser = pkt_cnt[WIDTH_TUSER-1:0]; tlast = (beat == len-1). A handshake (tvalid & tready) increments the data counter (mod 2^WIDTH_TDATA, continuing across packets) and beat.
- Handshake on the tlast beat: pkt_cnt += 1, beat = 0. Then:
  - IDLE with done pulse if the stop flag is set, or if num_pkts != 0 and pkt_cnt+1 == num_pkts;
  - otherwise GAP if gap != 0;
  - otherwise stay in SEND, back-to-back with tvalid held high.
- GAP: tvalid = 0 for exactly gap cycles, then SEND. A stop arriving in GAP goes straight to IDLE with done.
- cfg_stop in SEND sets a sticky stop flag and never truncates a packet. Stop in IDLE is ignored. Start while busy is ignored.
- AXIS rules:
  - tvalid never drops without a handshake;
  - tdata, tuser and tlast are stable while tvalid & !tready;
  - tvalid does not depend combinationally on tready.
- pkt_cnt saturates at 16'hFFFF. tuser wraps naturally.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE.
- Start at cycle N -> first tvalid at N+1.
- Throughput is one beat per cycle while tready = 1.
- Gap G: tlast handshake at cycle T -> next first beat valid at T+1+G.
- done is asserted in the cycle after the final tlast handshake; busy is low in that same cycle.
- Reset mid-packet: outputs clear asynchronously. The packet is abandoned with no tlast.

## Structure
- axis_pkt_gen_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SEND, GAP};
  - default width localparams (WIDTH_TDATA/WIDTH_TUSER defaults 16/4, matching the FIFO wrapper).
- Single module, no sub-modules. The FSM and the beat/data/gap counters live in one always_ff.

## Test plan
- len=4, num_pkts=2, gap=0, seed=16'h0010, tready=1 -> 8 consecutive beats 0x10..0x17; tlast on 0x13 and 0x17; tuser 0,0,0,0,1,1,1,1; done one cycle after the last beat; pkt_cnt=2.
- len=3, gap=2, num_pkts=2, tready=1 -> tvalid pattern 1,1,1,0,0,1,1,1.
- Random tready (50%), len=5 -> tdata/tuser/tlast held stable while stalled; no beat lost or duplicated.
- num_pkts=0, len=8, stop asserted on beat 3 of packet 2 -> packet 2 completes all 8 beats with tlast, then IDLE; pkt_cnt=2.
- cfg_len=0 start -> no tvalid, busy stays 0. cfg_len=2000 -> packets of 1024 beats.
- rst low during SEND -> tvalid=0 immediately. After release, a new start begins from the new cfg_seed with tuser=0.
